// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and constants for the serial even-parity link
// Purpose: frame state encoding and line-level constants used by both the
//          transmitter and the receiver of the even-parity serial link.
// Ports:   none (package)
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic EVEN_OK   = 1'b0;

endpackage

// File: rtl/xor2_nor.sv
// rtl/xor2_nor.sv - structural 2-input XOR built from five 2-input NOR gates
// Purpose: XOR cell shared with the transmitter so both ends fold parity
//          through identical structure.
// Ports:   i_a, i_b - operands
//          o_s      - i_a ^ i_b
module xor2_nor (
   input  logic i_a,
   input  logic i_b,
   output logic o_s
);

   logic w_n1;
   logic w_n2;
   logic w_n3;
   logic w_n4;

   assign w_n1 = ~(i_a | i_b);
   assign w_n2 = ~(i_a | w_n1);
   assign w_n3 = ~(i_b | w_n1);
   // w_n4 is XNOR; the final NOR used as an inverter yields XOR
   assign w_n4 = ~(w_n2 | w_n3);
   assign o_s  = ~(w_n4 | w_n4);

endmodule

// File: rtl/serial_parity_rx.sv
// rtl/serial_parity_rx.sv - serial even-parity frame receiver
// Purpose: samples start bit, DATA_W data bits (LSB first), even-parity bit
//          and stop bit; rebuilds the word and flags parity/framing errors.
// Ports:   i_clk, i_reset   - clock, synchronous active-high reset
//          i_bit_in         - serial line value, qualified by i_bit_valid
//          i_bit_valid      - one-cycle strobe per line bit
//          o_data_out       - last received data word
//          o_frame_done     - one-cycle pulse when a frame completes
//          o_parity_err     - last frame failed even parity
//          o_framing_err    - last frame's stop bit was 0
//          o_busy           - a frame is in progress
module serial_parity_rx
   import parity_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_bit_in,
   input  logic              i_bit_valid,
   output logic [DATA_W-1:0] o_data_out,
   output logic              o_frame_done,
   output logic              o_parity_err,
   output logic              o_framing_err,
   output logic              o_busy
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_shift;
   logic                r_par;
   logic                w_par_next;
   logic                w_last_bit;

   logic [DATA_W-1:0]   r_data_out;
   logic                r_frame_done;
   logic                r_parity_err;
   logic                r_framing_err;
   logic                r_busy;

   // One fold cell serves both DATA and PARITY: in each case the new line
   // bit is folded into the running parity.
   xor2_nor u_par_xor (
      .i_a (r_par),
      .i_b (i_bit_in),
      .o_s (w_par_next)
   );

   assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

   always_comb begin
      w_state_next = r_state;
      if (i_bit_valid) begin
         case (r_state)
            IDLE:    if (i_bit_in == START_BIT) w_state_next = DATA;
            DATA:    if (w_last_bit) w_state_next = PARITY;
            PARITY:  w_state_next = STOP;
            STOP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next != IDLE);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt         <= '0;
         r_shift       <= '0;
         r_par         <= 1'b0;
         r_data_out    <= '0;
         r_frame_done  <= 1'b0;
         r_parity_err  <= 1'b0;
         r_framing_err <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (i_bit_valid) begin
            case (r_state)
               IDLE: begin
                  if (i_bit_in == START_BIT) begin
                     r_cnt <= '0;
                     r_par <= 1'b0;
                  end
               end
               DATA: begin
                  // right shift: first bit received lands in bit 0
                  r_shift <= {i_bit_in, r_shift[DATA_W-1:1]};
                  r_par   <= w_par_next;
                  r_cnt   <= r_cnt + 1'b1;
               end
               PARITY: begin
                  r_par <= w_par_next;
               end
               STOP: begin
                  r_data_out    <= r_shift;
                  r_parity_err  <= (r_par != EVEN_OK);
                  r_framing_err <= (i_bit_in != STOP_BIT);
                  r_frame_done  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_data_out    = r_data_out;
   assign o_frame_done  = r_frame_done;
   assign o_parity_err  = r_parity_err;
   assign o_framing_err = r_framing_err;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_serial_parity_rx.sv
// tb/tb_serial_parity_rx.sv - scoreboard bench for serial_parity_rx
module tb_serial_parity_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       bit_in;
   logic       bit_valid;
   logic [7:0] data_out;
   logic       frame_done;
   logic       parity_err;
   logic       framing_err;
   logic       busy;

   logic       x_a;
   logic       x_b;
   logic       x_s;

   int n_checks = 0;
   int n_fail   = 0;

   // expected frame results: {data, parity_err, framing_err}
   logic [9:0] exp_q[$];
   logic       prev_fd = 1'b0;

   always #5 clk = ~clk;

   serial_parity_rx #(.DATA_W(8)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_bit_in      (bit_in),
      .i_bit_valid   (bit_valid),
      .o_data_out    (data_out),
      .o_frame_done  (frame_done),
      .o_parity_err  (parity_err),
      .o_framing_err (framing_err),
      .o_busy        (busy)
   );

   xor2_nor u_xor_chk (
      .i_a (x_a),
      .i_b (x_b),
      .o_s (x_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard whenever the DUT reports a completed frame
   always @(negedge clk) begin
      if (frame_done) begin
         if (prev_fd) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_width: got 2+ cycles expected 1");
         end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame_done: got pulse expected none");
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            check("sb_data_out", {24'd0, data_out}, {24'd0, e[9:2]});
            check("sb_parity_err", {31'd0, parity_err}, {31'd0, e[1]});
            check("sb_framing_err", {31'd0, framing_err}, {31'd0, e[0]});
            check("sb_busy_at_done", {31'd0, busy}, 32'd0);
         end
      end
      prev_fd <= frame_done;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic b);
      bit_valid = 1'b1;
      bit_in    = b;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      bit_in    = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gap);
      exp_q.push_back({d, (^d) ^ par, ~stp});
      strobe(1'b0);
      for (int i = 0; i < 8; i++) begin
         tick(gap);
         strobe(d[i]);
      end
      tick(gap);
      strobe(par);
      tick(gap);
      strobe(stp);
   endtask

   initial begin
      reset     = 1'b1;
      bit_in    = 1'b1;
      bit_valid = 1'b0;
      x_a       = 1'b0;
      x_b       = 1'b0;
      tick(3);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_parity_err", {31'd0, parity_err}, 32'd0);
      check("rst_framing_err", {31'd0, framing_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      tick(2);

      // good frame A5, back-to-back
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      check("a5_done_latency", {31'd0, frame_done}, 32'd1);
      tick(1);
      check("a5_done_one_cycle", {31'd0, frame_done}, 32'd0);
      check("a5_busy_after", {31'd0, busy}, 32'd0);
      tick(2);

      // parity error then a clearing good frame
      send_frame(8'h07, 1'b0, 1'b1, 0);
      tick(2);
      send_frame(8'h03, 1'b0, 1'b1, 0);
      tick(1);
      check("parity_err_cleared", {31'd0, parity_err}, 32'd0);
      tick(1);

      // framing error, immediate restart
      send_frame(8'h01, 1'b1, 1'b0, 0);
      check("ferr_fsm_idle", {31'd0, busy}, 32'd0);
      strobe(1'b0);
      check("restart_busy", {31'd0, busy}, 32'd1);
      exp_q.push_back({8'h5A, 1'b0, 1'b0});
      for (int i = 0; i < 8; i++) strobe(8'h5A >> i);
      strobe(1'b0);
      strobe(1'b1);
      tick(2);

      // idle-line strobes, then gapped 3C frame
      for (int i = 0; i < 3; i++) begin
         strobe(1'b1);
         check("idle_strobe_busy", {31'd0, busy}, 32'd0);
         tick(2);
      end
      send_frame(8'h3C, 1'b0, 1'b1, 5);
      check("gap_done_latency", {31'd0, frame_done}, 32'd1);
      tick(1);
      check("gap_done_one_cycle", {31'd0, frame_done}, 32'd0);
      tick(3);

      // reset after 4 data bits
      strobe(1'b0);
      for (int i = 0; i < 4; i++) strobe(1'b1);
      check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("mid_rst_data_out", {24'd0, data_out}, 32'd0);
      check("mid_rst_parity_err", {31'd0, parity_err}, 32'd0);
      check("mid_rst_framing_err", {31'd0, framing_err}, 32'd0);
      check("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 6; i++) strobe(1'b1);
      tick(3);
      send_frame(8'hFF, 1'b0, 1'b1, 0);
      tick(2);

      // drain scoreboard with a bound
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
      check("sb_drained", exp_q.size(), 32'd0);

      for (int i = 0; i < 4; i++) begin
         logic [3:0] exp_s;
         exp_s = 4'b0110;
         x_a = i[1];
         x_b = i[0];
         #1;
         check("xor2_nor_s", {31'd0, x_s}, {31'd0, exp_s[i]});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
